// File: rtl/bcd_conv_sched.sv
// ---------------------------------------------------------------------------
// bcd_conv_sched
//
// Two-requester signed binary-to-BCD converter. A small scheduler grants one
// requester at a time; the granted operand is latched and converted with the
// double-dabble algorithm, one iteration per clock, N iterations in total.
// The result is presented as sign + three BCD digits.
//
// Build option:
//   BCD_SCHED_RR_EN  defined   -> round-robin arbitration between requesters
//                    undefined -> fixed priority, requester 0 always wins
//
// Ports:
//   clk      in   rising-edge clock for all state
//   reset    in   synchronous active-high reset
//   req0     in   requester 0 request, held until granted
//   bin0     in   requester 0 operand: [N] sign, [N-1:0] magnitude
//   req1     in   requester 1 request, held until granted
//   bin1     in   requester 1 operand: [N] sign, [N-1:0] magnitude
//   gnt      out  one-hot acceptance pulse (bit0 = req0, bit1 = req1)
//   busy     out  high while a conversion is in progress
//   done     out  one-cycle pulse, bcdOut freshly updated
//   done_id  out  owner of the result flagged by done
//   bcdOut   out  [12] sign, [11:8] hundreds, [7:4] tens, [3:0] ones
// ---------------------------------------------------------------------------
module bcd_conv_sched #(
    parameter int N = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [N:0]  bin0,
    input  logic        req1,
    input  logic [N:0]  bin1,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [12:0] bcdOut
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q,   state_d;
    logic [1:0]    gnt_q,     gnt_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [N-1:0]  mag_q,     mag_d;
    logic          sign_q,    sign_d;
    logic          owner_q,   owner_d;
    logic [11:0]   work_q,    work_d;
    logic [12:0]   bcd_q,     bcd_d;
    logic          done_id_q, done_id_d;
`ifdef BCD_SCHED_RR_EN
    logic          last_q,    last_d;
`endif

    logic          any_req;
    logic          pick_one;
    logic [11:0]   step;

    // One double-dabble iteration: correct every digit that would overflow
    // past 9 after doubling, then shift in the next magnitude bit.
    function automatic logic [11:0] dabble_step(input logic [11:0] w,
                                                input logic        b);
        logic [11:0] a;
        a = w;
        for (int d = 0; d < 3; d++) begin
            if (a[4*d +: 4] >= 4'd5) begin
                a[4*d +: 4] = a[4*d +: 4] + 4'd3;
            end
        end
        return {a[10:0], b};
    endfunction

    // Arbitration. pick_one = 1 selects requester 1. Under round-robin the
    // pointer resets to "last granted 1" so the first contended grant after
    // reset goes to requester 0, matching the fixed-priority build.
    always_comb begin
        any_req = req0 | req1;
`ifdef BCD_SCHED_RR_EN
        pick_one = req1 & (~req0 | ~last_q);
`else
        pick_one = req1 & ~req0;
`endif
    end

    // The magnitude register is shifted left every iteration, so its MSB is
    // always the bit N-1-cnt of the originally latched magnitude.
    assign step = dabble_step(work_q, mag_q[N-1]);

    // Next-state and datapath logic. Requests are only looked at in IDLE or
    // DONE; anything raised during CONV is simply not seen, so nothing is
    // queued. DONE lasts exactly one cycle, which gives the done pulse.
    always_comb begin
        state_d   = state_q;
        gnt_d     = 2'b00;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        sign_d    = sign_q;
        owner_d   = owner_q;
        work_d    = work_q;
        bcd_d     = bcd_q;
        done_id_d = done_id_q;
`ifdef BCD_SCHED_RR_EN
        last_d    = last_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (any_req) begin
                    state_d = CONV;
                    gnt_d   = pick_one ? 2'b10 : 2'b01;
                    mag_d   = pick_one ? bin1[N-1:0] : bin0[N-1:0];
                    sign_d  = pick_one ? bin1[N] : bin0[N];
                    owner_d = pick_one;
                    work_d  = 12'd0;
                    cnt_d   = '0;
`ifdef BCD_SCHED_RR_EN
                    last_d  = pick_one;
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end

            CONV: begin
                work_d = step;
                mag_d  = mag_q << 1;
                cnt_d  = cnt_q + CW'(1);
                // The final iteration's result goes straight to the output
                // register so it is visible together with done.
                if (cnt_q == CW'(N - 1)) begin
                    state_d   = DONE;
                    bcd_d     = {sign_q, step};
                    done_id_d = owner_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset overrides any event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            cnt_q     <= '0;
            mag_q     <= '0;
            sign_q    <= 1'b0;
            owner_q   <= 1'b0;
            work_q    <= 12'd0;
            bcd_q     <= 13'd0;
            done_id_q <= 1'b0;
`ifdef BCD_SCHED_RR_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            mag_q     <= mag_d;
            sign_q    <= sign_d;
            owner_q   <= owner_d;
            work_q    <= work_d;
            bcd_q     <= bcd_d;
            done_id_q <= done_id_d;
`ifdef BCD_SCHED_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q == CONV);
    assign done    = (state_q == DONE);
    assign done_id = done_id_q;
    assign bcdOut  = bcd_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// ---------------------------------------------------------------------------
// tb_bcd_conv_sched
//
// Self-checking bench for bcd_conv_sched. Expected {done_id, bcdOut} pairs
// are pushed into a scoreboard when a request is issued and popped by a
// monitor whenever done is seen. Arbitration expectations follow the same
// build option (BCD_SCHED_RR_EN) as the design.
// ---------------------------------------------------------------------------
module tb_bcd_conv_sched;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0;
    logic [8:0]  bin0;
    logic        req1;
    logic [8:0]  bin1;
    logic [1:0]  gnt;
    logic        busy;
    logic        done;
    logic        done_id;
    logic [12:0] bcdOut;

    int          checks = 0;
    int          errors = 0;
    logic [13:0] sb[$];
    logic [13:0] mon_exp;
`ifdef BCD_SCHED_RR_EN
    bit          tb_last;
`endif

    always #5 clk = ~clk;

    bcd_conv_sched #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .bin0    (bin0),
        .req1    (req1),
        .bin1    (bin1),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .bcdOut  (bcdOut)
    );

    // Reference conversion using plain integer arithmetic.
    function automatic logic [12:0] to_bcd(input logic [8:0] v);
        int m;
        m = int'(v[7:0]);
        return {v[8], 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    // Expected winner for the given request pattern (1 = requester 1).
    function automatic bit predict_winner(input bit r0, input bit r1);
`ifdef BCD_SCHED_RR_EN
        if (r0 && r1) return ~tb_last;
`else
        if (r0 && r1) return 1'b0;
`endif
        return r1 && !r0;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest pending
    // expectation; a done with nothing pending is itself an error.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done: got done_id=%b bcdOut=%h, required no done",
                         done_id, bcdOut);
            end else begin
                mon_exp = sb.pop_front();
                if ({done_id, bcdOut} !== mon_exp) begin
                    errors++;
                    $display("[TB] FAIL result: got done_id=%b bcdOut=%h, required done_id=%b bcdOut=%h",
                             done_id, bcdOut, mon_exp[13], mon_exp[12:0]);
                end
            end
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
`ifdef BCD_SCHED_RR_EN
        tb_last = 1'b1;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, busy, done, done_id, bcdOut} !== 18'd0) begin
            errors++;
            $display("[TB] FAIL reset_values: got gnt=%b busy=%b done=%b done_id=%b bcdOut=%h, required all zero",
                     gnt, busy, done, done_id, bcdOut);
        end
        reset = 1'b0;
`ifdef BCD_SCHED_RR_EN
        tb_last = 1'b1;
`endif
    endtask

    // One uncontended conversion. With noise set, req1 is pulsed for two
    // cycles mid-conversion and must be ignored.
    task automatic single_conv(input bit id, input logic [8:0] val, input bit noise);
        logic [12:0] exp;
        int n;
        @(negedge clk);
        if (id) begin
            req1 = 1'b1;
            bin1 = val;
        end else begin
            req0 = 1'b1;
            bin0 = val;
        end
        exp = to_bcd(val);
        sb.push_back({id, exp});
        @(negedge clk);
        checks++;
        if (gnt !== (id ? 2'b10 : 2'b01) || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL accept: got gnt=%b busy=%b, required gnt=%b busy=1",
                     gnt, busy, id ? 2'b10 : 2'b01);
        end
`ifdef BCD_SCHED_RR_EN
        tb_last = id;
`endif
        req0 = 1'b0;
        req1 = 1'b0;
        bin0 = ~val;
        bin1 = ~val;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            if (noise) req1 = (n == 2 || n == 3);
            if (done !== 1'b1) begin
                checks++;
                if (gnt !== 2'b00 || busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL conv_phase: got gnt=%b busy=%b, required gnt=00 busy=1",
                             gnt, busy);
                end
            end
        end
        req1 = 1'b0;
        checks++;
        if (n != N || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL latency: got %0d cycles busy=%b, required %0d cycles busy=0",
                     n, busy, N);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || bcdOut !== exp || done_id !== id) begin
            errors++;
            $display("[TB] FAIL hold: got done=%b bcdOut=%h done_id=%b, required done=0 bcdOut=%h done_id=%b",
                     done, bcdOut, done_id, exp, id);
        end
    endtask

    task automatic test_single();
        single_conv(1'b0, 9'h0FF, 1'b0);
        single_conv(1'b1, 9'h12A, 1'b0);
        single_conv(1'b0, 9'h100, 1'b0);
        single_conv(1'b1, 9'd99, 1'b0);
    endtask

    task automatic test_ignore_in_conv();
        single_conv(1'b0, 9'h000, 1'b1);
    endtask

    task automatic test_reset_abort();
        pulse_reset();
        @(negedge clk);
        req0 = 1'b1;
        bin0 = 9'h0C8;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("[TB] FAIL abort_accept: got gnt=%b, required 01", gnt);
        end
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`ifdef BCD_SCHED_RR_EN
        tb_last = 1'b1;
`endif
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcdOut !== 13'd0 || gnt !== 2'b00) begin
            errors++;
            $display("[TB] FAIL abort_state: got busy=%b done=%b bcdOut=%h gnt=%b, required all zero",
                     busy, done, bcdOut, gnt);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bcdOut !== 13'd0) begin
            errors++;
            $display("[TB] FAIL abort_idle: got busy=%b bcdOut=%h, required busy=0 bcdOut=0000",
                     busy, bcdOut);
        end
        single_conv(1'b0, 9'h0C8, 1'b0);
    endtask

    // Both requesters held high for three back-to-back conversions.
    task automatic test_back_to_back();
        bit          w;
        logic [1:0]  exp_gnt;
        int          n;
        pulse_reset();
        @(negedge clk);
        bin0 = 9'd100;
        bin1 = 9'd7;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w       = predict_winner(1'b1, 1'b1);
            exp_gnt = w ? 2'b10 : 2'b01;
            sb.push_back({w, to_bcd(w ? bin1 : bin0)});
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (gnt === 2'b00 && n < 20);
            checks++;
            if (gnt !== exp_gnt || n > 10) begin
                errors++;
                $display("[TB] FAIL b2b_grant%0d: got gnt=%b after %0d cycles, required gnt=%b",
                         k, gnt, n, exp_gnt);
            end
`ifdef BCD_SCHED_RR_EN
            tb_last = w;
`endif
            if (k == 2) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            n = 0;
            while (done !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n != N) begin
                errors++;
                $display("[TB] FAIL b2b_latency%0d: got %0d cycles, required %0d", k, n, N);
            end
        end
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_end: got gnt=%b busy=%b done=%b, required all zero",
                     gnt, busy, done);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            single_conv(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        bin0  = 9'd0;
        bin1  = 9'd0;
`ifdef BCD_SCHED_RR_EN
        tb_last = 1'b1;
`endif
        test_reset();
        test_single();
        test_ignore_in_conv();
        test_reset_abort();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending results, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
